// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Memory-side bus between the load/store unit (master) and the data memory
// or interconnect (slave).
//   o_bus_valid  master->slave  access request, held until i_bus_ready
//   o_bus_we     master->slave  1 = write
//   o_bus_addr   master->slave  word address, bits[1:0] = 00
//   o_bus_wdata  master->slave  lane-replicated store data
//   o_bus_be     master->slave  byte enables
//   i_bus_ready  slave->master  access accepted / read data valid
//   i_bus_rdata  slave->master  read word, valid with i_bus_ready
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        o_bus_valid;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        input  i_bus_ready, i_bus_rdata
    );

    modport slave (
        input  o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        output i_bus_ready, i_bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit sitting in the M stage. Checks alignment/legality,
// issues one bus access, aligns and extends load data, and aborts accesses
// that see no i_bus_ready within TIMEOUT_CYCLES bus cycles.
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   i_req      memory access present in M stage
//   i_we       1 = store, 0 = load
//   i_funct3   RV32I width/sign code
//   i_addr     byte address
//   i_wdata    right-aligned store data
//   o_rdata    registered, aligned/extended load result (0 for stores/errors)
//   o_stall    hold the pipeline
//   o_done     one-cycle pulse on successful completion
//   o_err      one-cycle pulse on misaligned, illegal or timed-out access
//   bus        memory bus (master side)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_err,
    load_store_unit_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  tmo_cnt;

    logic        acc_ok;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    // Legality, alignment and store-lane formatting of the incoming request.
    always_comb begin
        acc_ok  = 1'b0;
        be_n    = 4'b1111;
        wdata_n = i_wdata;
        case (i_funct3)
            3'b000: begin
                acc_ok = 1'b1;
                if (i_we) begin
                    be_n    = 4'b0001 << i_addr[1:0];
                    wdata_n = {4{i_wdata[7:0]}};
                end
            end
            3'b001: begin
                acc_ok = !i_addr[0];
                if (i_we) begin
                    be_n    = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{i_wdata[15:0]}};
                end
            end
            3'b010:          acc_ok = (i_addr[1:0] == 2'b00);
            3'b100:          acc_ok = !i_we;
            3'b101:          acc_ok = !i_we && !i_addr[0];
            default:         acc_ok = 1'b0;
        endcase
    end

    // Load alignment from the returned word using the latched offset.
    always_comb begin
        byte_v = i_bus_rdata_sel(off_q);
        half_v = off_q[1] ? bus.i_bus_rdata[31:16] : bus.i_bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b010:  load_v = bus.i_bus_rdata;
            3'b100:  load_v = {24'h000000, byte_v};
            3'b101:  load_v = {16'h0000, half_v};
            default: load_v = '0;
        endcase
    end

    function automatic logic [7:0] i_bus_rdata_sel(input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = bus.i_bus_rdata[7:0];
            2'd1:    b = bus.i_bus_rdata[15:8];
            2'd2:    b = bus.i_bus_rdata[23:16];
            default: b = bus.i_bus_rdata[31:24];
        endcase
        return b;
    endfunction

    // Stall is combinational so the request cycle itself holds the pipeline.
    assign o_stall = ((state == S_IDLE) && i_req) || (state == S_REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            we_q            <= 1'b0;
            funct3_q        <= '0;
            off_q           <= '0;
            tmo_cnt         <= '0;
            o_rdata         <= '0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            bus.o_bus_valid <= 1'b0;
            bus.o_bus_we    <= 1'b0;
            bus.o_bus_addr  <= '0;
            bus.o_bus_wdata <= '0;
            bus.o_bus_be    <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        if (!acc_ok) begin
                            state   <= S_ERR;
                            o_err   <= 1'b1;
                            o_rdata <= '0;
                        end else begin
                            state           <= S_REQ;
                            we_q            <= i_we;
                            funct3_q        <= i_funct3;
                            off_q           <= i_addr[1:0];
                            tmo_cnt         <= '0;
                            bus.o_bus_valid <= 1'b1;
                            bus.o_bus_we    <= i_we;
                            bus.o_bus_addr  <= {i_addr[31:2], 2'b00};
                            bus.o_bus_wdata <= wdata_n;
                            bus.o_bus_be    <= be_n;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.i_bus_ready) begin
                        state           <= S_DONE;
                        o_done          <= 1'b1;
                        o_rdata         <= we_q ? '0 : load_v;
                        bus.o_bus_valid <= 1'b0;
                        bus.o_bus_we    <= 1'b0;
                    end else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state           <= S_ERR;
                        o_err           <= 1'b1;
                        o_rdata         <= '0;
                        bus.o_bus_valid <= 1'b0;
                        bus.o_bus_we    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                // i_req is still the already-served instruction here.
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: the stimulus process pushes expected bus requests and
// responses computed by a byte/half arithmetic model; a monitor pops and
// compares them whenever the DUT shows a bus request or a done/err pulse.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TMO = 16;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int unsigned vcycles;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_done;
    logic        o_err;

    load_store_unit_if bus_if ();

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_we     (i_we),
        .i_funct3 (i_funct3),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_rdata  (o_rdata),
        .o_stall  (o_stall),
        .o_done   (o_done),
        .o_err    (o_err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];
    bus_t  bus_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on byte offsets and sizes.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int unsigned wait_n,
                         output resp_t r, output bus_t b, output bit legal);
        int unsigned off   = addr % 4;
        int unsigned sz    = f3 % 4;
        bit          unsg  = (f3 >= 4);
        bit          ill   = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        bit          mis   = (sz == 1 && (addr % 2) != 0) || (sz == 2 && off != 0);
        int unsigned bytev = (rd >> (8 * off)) & 255;
        int unsigned halfv = (rd >> (16 * (off / 2))) & 65535;
        logic [31:0] ld;
        legal   = !ill && !mis;
        b.we    = we;
        b.addr  = addr - off;
        b.be    = 4'hF;
        b.wdata = wd;
        if (we && sz == 0) begin
            b.be    = 4'(1 << off);
            b.wdata = (wd & 32'hFF) * 32'h01010101;
        end else if (we && sz == 1) begin
            b.be    = (off >= 2) ? 4'hC : 4'h3;
            b.wdata = (wd & 32'hFFFF) * 32'h00010001;
        end
        if (sz == 0)
            ld = (unsg || bytev < 128) ? bytev : bytev - 32'd256;
        else if (sz == 1)
            ld = (unsg || halfv < 32768) ? halfv : halfv - 32'd65536;
        else
            ld = rd;
        if (!legal)             r = '{1'b1, 32'h0, 0};
        else if (wait_n >= TMO) r = '{1'b1, 32'h0, TMO};
        else                    r = '{1'b0, we ? 32'h0 : ld, wait_n + 1};
    endtask

    // Monitor: bus requests and responses against the scoreboard queues.
    int unsigned vcnt = 0;
    logic [31:0] last_rdata = '0;
    bus_t        cur_bus;
    resp_t       cur_resp;

    always @(negedge clk) begin
        if (!rst) begin
            vcnt       = 0;
            last_rdata = '0;
        end else begin
            if (bus_if.o_bus_valid) begin
                if (vcnt == 0) begin
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bus: got valid expected none at %0t", $time);
                    end else cur_bus = bus_q.pop_front();
                end
                vcnt++;
                check("bus_we",   {31'b0, bus_if.o_bus_we}, {31'b0, cur_bus.we});
                check("bus_addr", bus_if.o_bus_addr, cur_bus.addr);
                check("bus_be",   {28'b0, bus_if.o_bus_be}, {28'b0, cur_bus.be});
                if (cur_bus.we) check("bus_wdata", bus_if.o_bus_wdata, cur_bus.wdata);
            end
            if (o_done || o_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got done=%b err=%b expected none", o_done, o_err);
                end else begin
                    cur_resp = exp_q.pop_front();
                    check("resp_err",  {31'b0, o_err},  {31'b0, cur_resp.err});
                    check("resp_done", {31'b0, o_done}, {31'b0, !cur_resp.err});
                    check("resp_rdata", o_rdata, cur_resp.rdata);
                    check("valid_cycles", vcnt, cur_resp.vcycles);
                end
                vcnt       = 0;
                last_rdata = o_rdata;
            end else begin
                check("rdata_hold", o_rdata, last_rdata);
            end
        end
    end

    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int unsigned wait_n, input bit hold);
        resp_t       r;
        bus_t        b;
        bit          legal;
        bit          fin = 1'b0;
        int unsigned vc = 0;
        model(we, f3, addr, wd, rd, wait_n, r, b, legal);
        exp_q.push_back(r);
        if (legal) bus_q.push_back(b);
        @(negedge clk);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        bus_if.i_bus_rdata = rd;
        bus_if.i_bus_ready = 1'($urandom % 2);
        #1 check("stall_req", {31'b0, o_stall}, 32'd1);
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (o_done || o_err) begin
                fin = 1'b1;
                check("stall_end", {31'b0, o_stall}, 32'd0);
            end else begin
                check("stall_busy", {31'b0, o_stall}, 32'd1);
            end
            if (bus_if.o_bus_valid) begin
                vc++;
                bus_if.i_bus_ready = (vc == wait_n + 1);
            end else begin
                bus_if.i_bus_ready = 1'($urandom % 2);
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL access_timeout: got no done/err expected response within 60 cycles");
        end
        if (hold) @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic reset_mid_access();
        resp_t r;
        bus_t  b;
        bit    legal;
        model(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 0, r, b, legal);
        bus_q.push_back(b);
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h200; i_wdata = 32'hCAFEF00D;
        bus_if.i_bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, bus_if.o_bus_valid}, 32'd0);
        check("rst_we",    {31'b0, bus_if.o_bus_we}, 32'd0);
        check("rst_addr",  bus_if.o_bus_addr, 32'd0);
        check("rst_wdata", bus_if.o_bus_wdata, 32'd0);
        check("rst_be",    {28'b0, bus_if.o_bus_be}, 32'd0);
        check("rst_stall_req", {31'b0, o_stall}, 32'd1);
        i_req = 1'b0;
        #1 check("rst_stall_idle", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_valid", {31'b0, bus_if.o_bus_valid}, 32'd0);
            check("post_rst_pulse", {30'b0, o_done, o_err}, 32'd0);
            check("post_rst_stall", {31'b0, o_stall}, 32'd0);
        end
    endtask

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int unsigned wn;
        bus_if.i_bus_ready = 1'b0;
        bus_if.i_bus_rdata = '0;
        @(negedge clk);
        check("reset_valid", {31'b0, bus_if.o_bus_valid}, 32'd0);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_pulse", {30'b0, o_done, o_err}, 32'd0);
        check("reset_be",    {28'b0, bus_if.o_bus_be}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1'b1);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 1'b0);
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 1'b0);
        do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 1'b0);
        do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b1);
        do_access(1'b1, 3'b010, 32'h104, 32'h55AA55AA, 32'h0, 100, 1'b0);
        do_access(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF0000, TMO - 1, 1'b0);
        reset_mid_access();

        for (int n = 0; n < 250; n++) begin
            we   = 1'($urandom % 2);
            f3   = 3'($urandom % 8);
            addr = $urandom;
            if ($urandom % 4 != 0) addr = addr & ~32'((1 << (f3 % 4)) - 1);
            wn   = ($urandom % 12 == 0) ? 20 : $urandom % 4;
            do_access(we, f3, addr, $urandom, $urandom, wn, 1'($urandom % 2));
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: core data width; only 32 is supported.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles before an access is aborted; legal range 2..255.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  memory access present in M stage.
REQ-006 i_we  input  1  1=store, 0=load.
REQ-007 i_funct3  input  3  RV32I load/store width/sign code.
REQ-008 i_addr  input  32  byte address from M stage.
REQ-009 i_wdata  input  32  store data, right-aligned.
REQ-010 o_rdata  output  32  aligned, extended load result.
REQ-011 o_stall  output  1  hold the pipeline.
REQ-012 o_done  output  1  one-cycle pulse on successful completion.
REQ-013 o_err  output  1  one-cycle pulse on a misaligned, illegal or timed-out access.
REQ-014 o_bus_valid  output  1  bus request.
REQ-015 o_bus_we  output  1  bus write.
REQ-016 o_bus_addr  output  32  word address, bits[1:0]=00.
REQ-017 o_bus_wdata  output  32  lane-replicated store data.
REQ-018 o_bus_be  output  4  byte enables.
REQ-019 i_bus_ready  input  1  bus accepts or returns data this cycle.
REQ-020 i_bus_rdata  input  32  read word, valid when i_bus_ready=1.

Function
REQ-021 FSM states are IDLE, REQ, DONE and ERR; reset state is IDLE.
REQ-022 IDLE with i_req=1 and a legal, aligned access: latch we, funct3, addr[1:0], bus address, wdata and be, then go to REQ.
REQ-023 IDLE with i_req=1 and an illegal funct3 (loads 011/110/111, stores other than 000/001/010) or a misalignment (half with addr[0]=1, word with addr[1:0]!=0): go to ERR with no bus access.
REQ-024 o_stall is 1 when in IDLE with i_req=1, or when in REQ; it is 0 in DONE and ERR.
REQ-025 In REQ, o_bus_valid=1 and all o_bus_* outputs are held stable until i_bus_ready=1.
REQ-026 REQ with i_bus_ready=1: go to DONE; for loads, capture i_bus_rdata.
REQ-027 REQ timeout: a counter is cleared on REQ entry and increments each REQ cycle; after TIMEOUT_CYCLES REQ cycles without ready, go to ERR.
REQ-028 In DONE, o_done=1 for one cycle, then go to IDLE; i_req is ignored in DONE because it is the same, already-served instruction.
REQ-029 In ERR, o_err=1 for one cycle, then go to IDLE.
REQ-030 o_rdata is registered and updated on entry to DONE or ERR, then held until the next update:
- load: extended result;
- store: 0;
- error: 0.
REQ-031 Load extraction: select the byte by addr[1:0] and the half by addr[1].
- LB/LH (000/001): sign-extended.
- LBU/LHU (100/101): zero-extended.
- LW (010): the full word.
REQ-032 Store lanes:
- SB: be=0001 shifted left by addr[1:0]; wdata = byte replicated x4.
- SH: be=0011 if addr[1]=0, else 1100; wdata = half replicated x2.
- SW: be=1111.
REQ-033 o_bus_we=0 for loads; o_bus_be is 1111 for loads.
REQ-034 i_bus_ready outside REQ is ignored.
REQ-035 Minimum latency is 3 cycles: request in cycle 0, o_bus_valid in cycle 1, ready in cycle 1, o_done in cycle 2.

Reset
REQ-036 rst=0 asynchronously forces the following, regardless of state, including mid-access:
- state=IDLE;
- o_bus_valid=0, o_bus_we=0;
- o_stall follows REQ-024 (i.e. equals i_req);
- o_done=0, o_err=0;
- o_rdata=0, o_bus_addr=0, o_bus_wdata=0, o_bus_be=0;
- timeout counter=0.
REQ-037 An access interrupted by reset is dropped, not replayed.

Verification
REQ-038 LW addr 0x100, ready after 2 wait cycles with rdata 0xDEADBEEF -> o_bus_addr=0x100, be=1111; o_stall high in cycles 0-3; o_done pulse in cycle 4; o_rdata=0xDEADBEEF.
REQ-039 LB addr 0x103 with rdata 0x80123456 -> o_rdata=0xFFFFFF80; LBU, same stimulus -> 0x00000080; LHU addr 0x102 -> 0x00008012.
REQ-040 SH addr 0x102 with wdata 0x1234ABCD -> o_bus_addr=0x100, be=1100, o_bus_wdata=0xABCDABCD, o_bus_we=1; o_rdata=0 after DONE.
REQ-041 LW addr 0x102 -> no o_bus_valid; o_err pulse in cycle 1; o_rdata=0; returns to IDLE in cycle 2.
REQ-042 Store with i_bus_ready held 0 -> o_bus_valid high for exactly 16 cycles, then one o_err pulse, then o_stall low.
REQ-043 rst=0 in the second REQ cycle -> o_bus_valid drops in the same cycle without waiting for a clock edge; after release with i_req=0, FSM is in IDLE with no o_done/o_err.
